// File: rtl/aes_pkg.sv
// Shared AES constants: forward and inverse S-box tables, FIPS-197 byte order.
// INV_SBOX_TABLE[SBOX_TABLE[x]] == x for every byte x.
package aes_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [BYTE_W-1:0] INV_SBOX_TABLE [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox_lut.sv
// Combinational AES inverse S-box: a 256-entry constant ROM lookup.
// Also used unregistered elsewhere in the decryption datapath.
module inv_sbox_lut
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    output logic [BYTE_W-1:0] byte_o
);

    assign byte_o = INV_SBOX_TABLE[byte_i];

endmodule

// File: rtl/inv_sbox_reg.sv
// Registered AES inverse S-box: one-cycle latency, full throughput, valid-qualified.
// The data register only loads on valid input, so idle cycles hold the last result.
module inv_sbox_reg
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_byte
);

    logic [BYTE_W-1:0] lut_byte;
    logic [BYTE_W-1:0] out_byte_d, out_byte_q;
    logic              out_valid_d, out_valid_q;

    inv_sbox_lut u_lut (
        .byte_i (in_byte),
        .byte_o (lut_byte)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        out_valid_d = in_valid;
        out_byte_d  = out_byte_q;
        if (in_valid) begin
            out_byte_d = lut_byte;
        end
    end

    // NOTE: non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;

endmodule

// File: tb/tb_inv_sbox_reg.sv
// Self-checking bench for inv_sbox_reg: scoreboard of expected results, model built
// from GF(2^8) arithmetic, plus directed literals, sweeps and async reset cases.
module tb_inv_sbox_reg;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       out_valid;
    logic [7:0] out_byte;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] hold_byte;
    logic [7:0] sbox_m [256];
    logic [7:0] inv_m  [256];
    bit         seen   [256];
    bit         collect;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] dir_in  [11] = '{8'h00, 8'h23, 8'h56, 8'ha3, 8'h4e, 8'h19, 8'hff, 8'hcc, 8'hdf, 8'h63, 8'h52};
    logic [7:0] dir_exp [11] = '{8'h52, 8'h32, 8'hb9, 8'h71, 8'hb6, 8'h8e, 8'h7d, 8'h27, 8'hef, 8'h00, 8'h48};

    inv_sbox_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_byte  (out_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        for (int c = 1; c < 256; c++) begin
            if (gmul(a, c[7:0]) == 8'h01) return c[7:0];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_valid", int'(out_valid), int'(e.valid));
            check("out_byte", int'(out_byte), int'(e.data));
            if (collect && e.valid) seen[out_byte] = 1'b1;
        end
    endtask

    // One cycle: check the result of the previous edge, then drive the next input.
    task automatic step(input logic v, input logic [7:0] b, input logic [7:0] exp_byte);
        @(negedge clk);
        compare_out();
        in_valid = v;
        in_byte  = b;
        if (v) hold_byte = exp_byte;
        exp_q.push_back('{valid: v, data: hold_byte});
    endtask

    initial begin
        int distinct;

        for (int x = 0; x < 256; x++) sbox_m[x] = fwd_sbox(x[7:0]);
        for (int x = 0; x < 256; x++) inv_m[sbox_m[x]] = x[7:0];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        hold_byte = 8'h00;
        collect   = 1'b0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_byte", int'(out_byte), 0);
        repeat (2) @(negedge clk);
        check("rst_hold_valid", int'(out_valid), 0);
        check("rst_hold_byte", int'(out_byte), 0);
        rst = 1'b0;

        // Directed vectors, back to back, against literal expectations.
        for (int i = 0; i < 11; i++) step(1'b1, dir_in[i], dir_exp[i]);

        // Valid gating: result holds, valid drops for idle cycles.
        step(1'b1, 8'h56, 8'hb9);
        step(1'b0, 8'haa, 8'h00);
        step(1'b0, 8'haa, 8'h00);

        // Exhaustive sweep against the arithmetic model.
        collect = 1'b1;
        for (int x = 0; x < 256; x++) step(1'b1, x[7:0], inv_m[x]);
        step(1'b0, 8'h00, 8'h00);
        collect = 1'b0;
        distinct = 0;
        for (int x = 0; x < 256; x++) if (seen[x]) distinct++;
        check("bijection", distinct, 256);

        // Round trip through the forward table.
        for (int x = 0; x < 256; x++) step(1'b1, SBOX_TABLE[x], x[7:0]);
        step(1'b0, 8'h00, 8'h00);

        // Reset mid-stream, asserted between edges before the 56 result lands.
        step(1'b1, 8'h00, 8'h52);
        step(1'b1, 8'h23, 8'h32);
        step(1'b1, 8'h56, 8'hb9);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_byte", int'(out_byte), 0);
        exp_q.delete();
        hold_byte = 8'h00;
        @(posedge clk);
        #1;
        check("rst_edge_valid", int'(out_valid), 0);
        check("rst_edge_byte", int'(out_byte), 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step(1'b1, 8'hff, 8'h7d);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        @(negedge clk);
        compare_out();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
